axi4lite_protocol_checker: RTL

Synthesizable AXI4-Lite bus checker; passive tap on a single master/slave interface.
Tracks outstanding transactions and checks VALID/payload stability, response legality, outstanding overflow and stall timeouts.
Reports violations as sticky error bits, a one-cycle pulse and a first-error ID.
Sits beside the DUT in emulation/FPGA builds and in formal/sim benches as a monitor.

---
 rtl/axi4lite_chk_pkg.sv | 43 ++++
 rtl/axi4lite_protocol_checker_if.sv | 35 +++
 rtl/axi4lite_chk_chan.sv | 48 ++++
 rtl/axi4lite_protocol_checker.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/axi4lite_chk_pkg.sv
// Shared error IDs, response codes and sizing helpers for the AXI4-Lite protocol checker.
package axi4lite_chk_pkg;

    localparam int unsigned NUM_ERR  = 10;
    localparam int unsigned ERR_ID_W = 4;

    typedef enum logic [ERR_ID_W-1:0] {
        ERR_AW_STABLE = 4'd0,
        ERR_W_STABLE  = 4'd1,
        ERR_B_STABLE  = 4'd2,
        ERR_AR_STABLE = 4'd3,
        ERR_R_STABLE  = 4'd4,
        ERR_W_UNEXP   = 4'd5,
        ERR_B_UNEXP   = 4'd6,
        ERR_R_UNEXP   = 4'd7,
        ERR_OVERFLOW  = 4'd8,
        ERR_TIMEOUT   = 4'd9
    } err_id_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int unsigned cnt_width(input int unsigned max_outs);
        return $clog2(max_outs + 1);
    endfunction

    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    // Lowest set error ID; zero when nothing is set.
    function automatic logic [ERR_ID_W-1:0] first_err(input logic [NUM_ERR-1:0] errs);
        logic [ERR_ID_W-1:0] id;
        id = '0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (errs[i]) id = ERR_ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/axi4lite_protocol_checker_if.sv
// AXI4-Lite bus bundle with master, slave and passive monitor views.
interface axi4lite_protocol_checker_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    AWVALID, AWREADY;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    WVALID, WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    BVALID, BREADY;
    logic [1:0]              BRESP;
    logic                    ARVALID, ARREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    RVALID, RREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport monitor (
        input AWVALID, AWREADY, AWADDR, AWPROT, WVALID, WREADY, WDATA, WSTRB,
              BVALID, BREADY, BRESP, ARVALID, ARREADY, ARADDR, ARPROT, RVALID, RREADY, RDATA, RRESP
    );
endinterface

// File: rtl/axi4lite_chk_chan.sv
// Per-channel monitor: stall snapshot, VALID/payload stability compare and stall timer.
module axi4lite_chk_chan
    import axi4lite_chk_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 1,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 valid,
    input  logic                 ready,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 stable_err,
    output logic                 stall_to
);
    localparam int unsigned     TW     = timer_width(TIMEOUT);
    localparam logic [TW-1:0]   T_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0]   T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic                 stall, stall_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [TW-1:0]        timer_q, timer_d;

    assign stall      = valid && !ready;
    assign stable_err = stall_q && (!valid || (payload != payload_q));

    // Timer flags in the cycle its count reaches TIMEOUT and saturates there.
    always_comb begin
        timer_d  = '0;
        stall_to = 1'b0;
        if ((TIMEOUT > 0) && stall) begin
            timer_d  = (timer_q == T_MAX) ? timer_q : timer_q + TW'(1);
            stall_to = (timer_q >= T_LAST);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            stall_q   <= 1'b0;
            payload_q <= '0;
            timer_q   <= '0;
        end else begin
            stall_q   <= stall;
            payload_q <= payload;
            timer_q   <= timer_d;
        end
    end
endmodule

// File: rtl/axi4lite_protocol_checker.sv
// Passive AXI4-Lite checker reporting sticky protocol errors and outstanding counts.
// Define AXI4LITE_CHK_ASSERT_EN to add concurrent assertions for sim/formal triage.
module axi4lite_protocol_checker
    import axi4lite_chk_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_OUTS   = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    axi4lite_protocol_checker_if.monitor    bus,
    input  logic                            clr_err,
    output logic [NUM_ERR-1:0]              err_vec,
    output logic                            err_pulse,
    output logic [ERR_ID_W-1:0]             err_first,
    output logic [cnt_width(MAX_OUTS)-1:0]  wr_outs,
    output logic [cnt_width(MAX_OUTS)-1:0]  rd_outs
);
    localparam int unsigned   CW     = cnt_width(MAX_OUTS);
    localparam int unsigned   TW     = timer_width(TIMEOUT);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [4:0]         stable_err, stall_to;
    logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic               w_unexp, b_unexp, r_unexp, overflow;
    logic [CW-1:0]      wd_cnt, wresp_cnt;
    logic [CW:0]        wr_step, wd_step, wresp_step, rd_step;
    logic [1:0]         age_run, age_to;
    logic [TW-1:0]      age_q [2];
    logic [TW-1:0]      age_d [2];
    logic [NUM_ERR-1:0] err_det, err_base, err_vec_d;
    logic               err_pulse_d;
    logic [ERR_ID_W-1:0] err_first_d;

    axi4lite_chk_chan #(.PAYLOAD_W(ADDR_WIDTH + 3), .TIMEOUT(TIMEOUT)) u_aw (
        .ACLK, .ARESETn, .valid(bus.AWVALID), .ready(bus.AWREADY),
        .payload({bus.AWADDR, bus.AWPROT}), .stable_err(stable_err[0]), .stall_to(stall_to[0]));
    axi4lite_chk_chan #(.PAYLOAD_W(DATA_WIDTH + DATA_WIDTH / 8), .TIMEOUT(TIMEOUT)) u_w (
        .ACLK, .ARESETn, .valid(bus.WVALID), .ready(bus.WREADY),
        .payload({bus.WDATA, bus.WSTRB}), .stable_err(stable_err[1]), .stall_to(stall_to[1]));
    axi4lite_chk_chan #(.PAYLOAD_W(2), .TIMEOUT(TIMEOUT)) u_b (
        .ACLK, .ARESETn, .valid(bus.BVALID), .ready(bus.BREADY),
        .payload(bus.BRESP), .stable_err(stable_err[2]), .stall_to(stall_to[2]));
    axi4lite_chk_chan #(.PAYLOAD_W(ADDR_WIDTH + 3), .TIMEOUT(TIMEOUT)) u_ar (
        .ACLK, .ARESETn, .valid(bus.ARVALID), .ready(bus.ARREADY),
        .payload({bus.ARADDR, bus.ARPROT}), .stable_err(stable_err[3]), .stall_to(stall_to[3]));
    axi4lite_chk_chan #(.PAYLOAD_W(DATA_WIDTH + 2), .TIMEOUT(TIMEOUT)) u_r (
        .ACLK, .ARESETn, .valid(bus.RVALID), .ready(bus.RREADY),
        .payload({bus.RDATA, bus.RRESP}), .stable_err(stable_err[4]), .stall_to(stall_to[4]));

    assign aw_hs = bus.AWVALID && bus.AWREADY;
    assign w_hs  = bus.WVALID  && bus.WREADY;
    assign b_hs  = bus.BVALID  && bus.BREADY;
    assign ar_hs = bus.ARVALID && bus.ARREADY;
    assign r_hs  = bus.RVALID  && bus.RREADY;

    assign w_unexp = bus.WVALID && (wd_cnt == '0) && !bus.AWVALID;
    assign b_unexp = bus.BVALID && ((wr_outs == '0) || (wresp_cnt == '0));
    assign r_unexp = bus.RVALID && (rd_outs == '0);

    // Returns {overflow, next}: saturating at both ends, inc+dec cancels.
    function automatic logic [CW:0] cnt_step(input logic [CW-1:0] cur, input logic inc, input logic dec);
        if (inc && !dec) return (cur == CW'(MAX_OUTS)) ? {1'b1, cur} : {1'b0, cur + CW'(1)};
        if (dec && !inc && (cur != '0)) return {1'b0, cur - CW'(1)};
        return {1'b0, cur};
    endfunction

    assign wr_step    = cnt_step(wr_outs,   aw_hs, b_hs && !b_unexp);
    assign wd_step    = cnt_step(wd_cnt,    aw_hs, w_hs && !w_unexp);
    assign wresp_step = cnt_step(wresp_cnt, w_hs,  b_hs && !b_unexp);
    assign rd_step    = cnt_step(rd_outs,   ar_hs, r_hs && !r_unexp);
    assign overflow   = wr_step[CW] | wd_step[CW] | wresp_step[CW] | rd_step[CW];

    // Response age: runs while transactions are outstanding and no response is offered.
    assign age_run = {(rd_outs != '0) && !bus.RVALID, (wr_outs != '0) && !bus.BVALID};

    always_comb begin
        age_to = '0;
        for (int i = 0; i < 2; i++) begin
            age_d[i] = '0;
            if ((TIMEOUT > 0) && age_run[i]) begin
                age_d[i]  = (age_q[i] == T_MAX) ? age_q[i] : age_q[i] + TW'(1);
                age_to[i] = (age_q[i] >= T_LAST);
            end
        end
    end

    always_comb begin
        err_det                = '0;
        err_det[ERR_AW_STABLE] = stable_err[0];
        err_det[ERR_W_STABLE]  = stable_err[1];
        err_det[ERR_B_STABLE]  = stable_err[2];
        err_det[ERR_AR_STABLE] = stable_err[3];
        err_det[ERR_R_STABLE]  = stable_err[4];
        err_det[ERR_W_UNEXP]   = w_unexp;
        err_det[ERR_B_UNEXP]   = b_unexp;
        err_det[ERR_R_UNEXP]   = r_unexp;
        err_det[ERR_OVERFLOW]  = overflow;
        err_det[ERR_TIMEOUT]   = (|stall_to) | (|age_to);
    end

    // A clear and a new error in the same cycle: the new error survives and becomes first.
    always_comb begin
        err_base    = clr_err ? '0 : err_vec;
        err_vec_d   = err_base | err_det;
        err_pulse_d = |(err_det & ~err_base);
        err_first_d = clr_err ? '0 : err_first;
        if ((err_base == '0) && (err_det != '0)) err_first_d = first_err(err_det);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_outs   <= '0;
            rd_outs   <= '0;
            wd_cnt    <= '0;
            wresp_cnt <= '0;
            age_q[0]  <= '0;
            age_q[1]  <= '0;
            err_vec   <= '0;
            err_pulse <= 1'b0;
            err_first <= '0;
        end else begin
            wr_outs   <= wr_step[CW-1:0];
            rd_outs   <= rd_step[CW-1:0];
            wd_cnt    <= wd_step[CW-1:0];
            wresp_cnt <= wresp_step[CW-1:0];
            age_q[0]  <= age_d[0];
            age_q[1]  <= age_d[1];
            err_vec   <= err_vec_d;
            err_pulse <= err_pulse_d;
            err_first <= err_first_d;
        end
    end

`ifdef AXI4LITE_CHK_ASSERT_EN
    for (genvar i = 0; i < NUM_ERR; i++) begin : g_err_sva
        a_no_err: assert property (@(posedge ACLK) disable iff (!ARESETn) !$rose(err_vec[i]));
    end
    a_wr_outs_max: assert property (@(posedge ACLK) disable iff (!ARESETn) wr_outs <= CW'(MAX_OUTS));
    a_rd_outs_max: assert property (@(posedge ACLK) disable iff (!ARESETn) rd_outs <= CW'(MAX_OUTS));
`else
`endif
endmodule
